vga_timing_gen: RTL and testbench

//   Parametrised VGA sync/timing generator; next generation of our fixed 640x480 synchroniser.

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_pixel_tick.sv | 41 ++++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and helpers for the VGA timing generator family.
//   - Default 640x480@60 timing constants (pixel clock = CLK / 2).
//   - Helpers that derive line/frame totals and sync-window bounds
//     from the active/porch/sync widths.
//   - div_width(): counter width for the pixel-tick divider.
//   - sync_flags_t: the 1-bit decoded outputs bundled together so they
//     can be registered as a group.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_CNT_W    = 10;

    // Total pixels per line or lines per frame.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count value inside the sync pulse.
    function automatic int sync_first(input int active, input int fp);
        return active + fp;
    endfunction

    // Last count value inside the sync pulse.
    function automatic int sync_last(input int active, input int fp,
                                     input int sync);
        return active + fp + sync - 1;
    endfunction

    // Divider counter width; a divide-by-1 still needs a 1-bit register.
    function automatic int div_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

    typedef struct packed {
        logic sincro_horiz;
        logic sincro_vert;
        logic video_on;
        logic line_start;
        logic frame_start;
    } sync_flags_t;

endpackage

// File: rtl/vga_pixel_tick.sv
// ----------------------------------------------------------------------------
// vga_pixel_tick
//   Divides the system clock into a one-CLK-wide pixel enable.
//   div_cnt runs 0..CLK_DIV-1 and wraps; p_tick is high on the last count.
//   p_tick is forced low while RESET is high so the first tick after
//   release arrives exactly CLK_DIV cycles later.
// Ports
//   CLK    in  system clock
//   RESET  in  synchronous, active-high reset
//   p_tick out pixel enable, one CLK every CLK_DIV cycles
// ----------------------------------------------------------------------------
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RESET,
    output logic p_tick
);

    localparam int               DIV_W    = div_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // With CLK_DIV=1 div_cnt is stuck at 0 == DIV_LAST, so every
    // non-reset cycle ticks.
    assign p_tick = !RESET && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA sync/timing generator. A pixel tick derived from CLK
//   advances a horizontal counter; its wrap advances a vertical counter.
//   Sync pulses, video_on, pixel coordinates and line/frame strobes are
//   decoded from the registered counters.
//
// Configuration macro
//   VGA_TIMING_OUT_REG_EN : when defined, all decoded outputs (sincro_*,
//     video_on, pixel_X/Y, line_start, frame_start) pass through one
//     output register and lag p_tick by one CLK. When undefined the
//     outputs are combinational decodes with no added latency.
//
// Ports
//   CLK          in  system clock
//   RESET        in  synchronous, active-high reset
//   p_tick       out one-CLK pixel enable every CLK_DIV cycles
//   sincro_horiz out horizontal sync, asserted level HS_POL
//   sincro_vert  out vertical sync, asserted level VS_POL
//   video_on     out high inside the active picture area
//   pixel_X      out horizontal count 0..H_TOTAL-1 (blanking included)
//   pixel_Y      out vertical count 0..V_TOTAL-1 (blanking included)
//   line_start   out high on the tick CLK where pixel_X=0
//   frame_start  out high on the tick CLK where pixel_X=0 and pixel_Y=0
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             p_tick,
    output logic             sincro_horiz,
    output logic             sincro_vert,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_X,
    output logic [CNT_W-1:0] pixel_Y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_first(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_first(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_act;
    logic             vs_act;
    sync_flags_t      flags_p0;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .p_tick (tick)
    );

    assign p_tick = tick;

    // ---- counter stage: h/v counters advance only on a pixel tick ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // ---- decode stage p0: combinational view of the counter state ----
    always_comb begin
        hs_act = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_act = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

        flags_p0              = '0;
        flags_p0.sincro_horiz = hs_act ? HS_POL : ~HS_POL;
        flags_p0.sincro_vert  = vs_act ? VS_POL : ~VS_POL;
        flags_p0.video_on     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        // Strobes are tied to the tick so they last exactly one CLK.
        flags_p0.line_start   = tick && (h_cnt == '0);
        flags_p0.frame_start  = tick && (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef VGA_TIMING_OUT_REG_EN
    sync_flags_t      flags_p1;
    logic [CNT_W-1:0] pixel_x_p1;
    logic [CNT_W-1:0] pixel_y_p1;

    // ---- output stage p1: one register, reset to the idle decode ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_p1.sincro_horiz <= ~HS_POL;
            flags_p1.sincro_vert  <= ~VS_POL;
            flags_p1.video_on     <= 1'b1;
            flags_p1.line_start   <= 1'b0;
            flags_p1.frame_start  <= 1'b0;
            pixel_x_p1            <= '0;
            pixel_y_p1            <= '0;
        end else begin
            flags_p1   <= flags_p0;
            pixel_x_p1 <= h_cnt;
            pixel_y_p1 <= v_cnt;
        end
    end

    assign sincro_horiz = flags_p1.sincro_horiz;
    assign sincro_vert  = flags_p1.sincro_vert;
    assign video_on     = flags_p1.video_on;
    assign line_start   = flags_p1.line_start;
    assign frame_start  = flags_p1.frame_start;
    assign pixel_X      = pixel_x_p1;
    assign pixel_Y      = pixel_y_p1;
`else
    assign sincro_horiz = flags_p0.sincro_horiz;
    assign sincro_vert  = flags_p0.sincro_vert;
    assign video_on     = flags_p0.video_on;
    assign line_start   = flags_p0.line_start;
    assign frame_start  = flags_p0.frame_start;
    assign pixel_X      = h_cnt;
    assign pixel_Y      = v_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives five differently configured vga_timing_gen instances from one
//   clock and one shared reset. The reference model derives every output
//   from the number of CLK cycles since reset release using plain
//   arithmetic (tick index -> raster position -> window tests). Aggregate
//   statistics (line/frame period, sync and video cycle counts) are checked
//   during reset-free windows. Random reset pulses exercise restart.
//   Builds with or without VGA_TIMING_OUT_REG_EN.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int NI = 5;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int div;
        int hpol, vpol;
    } cfg_t;

    typedef struct {
        int pt, hs, vs, von, ls, fs, x, y;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic pt[NI], hs[NI], vs[NI], von[NI], ls[NI], fs[NI];
    logic [9:0]  px0, py0, px1, py1, px2, py2, px3, py3;
    logic [10:0] px4, py4;
    int pxa[NI], pya[NI];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Default build: 640x480, CLK_DIV=2, active-low syncs.
    vga_timing_gen u0 (
        .CLK(clk), .RESET(rst), .p_tick(pt[0]), .sincro_horiz(hs[0]),
        .sincro_vert(vs[0]), .video_on(von[0]), .pixel_X(px0), .pixel_Y(py0),
        .line_start(ls[0]), .frame_start(fs[0]));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10)
    ) u1 (
        .CLK(clk), .RESET(rst), .p_tick(pt[1]), .sincro_horiz(hs[1]),
        .sincro_vert(vs[1]), .video_on(von[1]), .pixel_X(px1), .pixel_Y(py1),
        .line_start(ls[1]), .frame_start(fs[1]));

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(1), .H_SYNC(6), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10)
    ) u2 (
        .CLK(clk), .RESET(rst), .p_tick(pt[2]), .sincro_horiz(hs[2]),
        .sincro_vert(vs[2]), .video_on(von[2]), .pixel_X(px2), .pixel_Y(py2),
        .line_start(ls[2]), .frame_start(fs[2]));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(10)
    ) u3 (
        .CLK(clk), .RESET(rst), .p_tick(pt[3]), .sincro_horiz(hs[3]),
        .sincro_vert(vs[3]), .video_on(von[3]), .pixel_X(px3), .pixel_Y(py3),
        .line_start(ls[3]), .frame_start(fs[3]));

    // 800x600 timing, positive syncs, pixel clock = CLK.
    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
    ) u4 (
        .CLK(clk), .RESET(rst), .p_tick(pt[4]), .sincro_horiz(hs[4]),
        .sincro_vert(vs[4]), .video_on(von[4]), .pixel_X(px4), .pixel_Y(py4),
        .line_start(ls[4]), .frame_start(fs[4]));

    always_comb begin
        pxa[0] = int'(px0); pya[0] = int'(py0);
        pxa[1] = int'(px1); pya[1] = int'(py1);
        pxa[2] = int'(px2); pya[2] = int'(py2);
        pxa[3] = int'(px3); pya[3] = int'(py3);
        pxa[4] = int'(px4); pya[4] = int'(py4);
    end

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0};
            1:       c = '{16, 2, 4, 3, 10, 1, 2, 2, 2, 0, 0};
            2:       c = '{20, 1, 6, 3, 12, 1, 2, 3, 1, 1, 1};
            3:       c = '{8, 1, 2, 1, 4, 1, 1, 1, 3, 1, 0};
            default: c = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 1};
        endcase
        return c;
    endfunction

    function automatic int h_tot(input cfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int v_tot(input cfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    // Expected combinational outputs for the cycle that is n CLKs after
    // reset release, given the RESET level during that cycle.
    function automatic obs_t model(input cfg_t c, input int n, input logic r);
        obs_t o;
        int ht, vt, pix;
        ht    = h_tot(c);
        vt    = v_tot(c);
        pix   = (n / c.div) % (ht * vt);
        o.x   = pix % ht;
        o.y   = pix / ht;
        o.pt  = (!r && (n % c.div == c.div - 1)) ? 1 : 0;
        o.hs  = (o.x >= c.ha + c.hfp && o.x < c.ha + c.hfp + c.hs) ? c.hpol : 1 - c.hpol;
        o.vs  = (o.y >= c.va + c.vfp && o.y < c.va + c.vfp + c.vs) ? c.vpol : 1 - c.vpol;
        o.von = (o.x < c.ha && o.y < c.va) ? 1 : 0;
        o.ls  = (o.pt == 1 && o.x == 0) ? 1 : 0;
        o.fs  = (o.ls == 1 && o.y == 0) ? 1 : 0;
        return o;
    endfunction

    function automatic obs_t idle_obs(input cfg_t c);
        obs_t o;
        o = '{0, 1 - c.hpol, 1 - c.vpol, 1, 0, 0, 0, 0};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            if (failed <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycles since reset release; -1 until the first reset edge is seen.
    int   n = -1;
    int   cyc = 0;
    obs_t exp_reg[NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++)
            exp_reg[i] <= rst ? idle_obs(get_cfg(i)) : model(get_cfg(i), n, rst);
        n   <= rst ? 0 : ((n < 0) ? -1 : n + 1);
        cyc <= cyc + 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (n >= 0) begin
            for (int i = 0; i < NI; i++) begin
                obs_t e, d;
                e = model(get_cfg(i), n, rst);
`ifdef VGA_TIMING_OUT_REG_EN
                d = exp_reg[i];
`else
                d = e;
`endif
                check($sformatf("u%0d p_tick", i),       32'(pt[i]),  32'(e.pt));
                check($sformatf("u%0d sincro_horiz", i), 32'(hs[i]),  32'(d.hs));
                check($sformatf("u%0d sincro_vert", i),  32'(vs[i]),  32'(d.vs));
                check($sformatf("u%0d video_on", i),     32'(von[i]), 32'(d.von));
                check($sformatf("u%0d line_start", i),   32'(ls[i]),  32'(d.ls));
                check($sformatf("u%0d frame_start", i),  32'(fs[i]),  32'(d.fs));
                check($sformatf("u%0d pixel_X", i),      pxa[i],      d.x);
                check($sformatf("u%0d pixel_Y", i),      pya[i],      d.y);
            end
        end
    end

    // Aggregate statistics over reset-free windows.
    logic agg_en = 1'b0;
    int   line_seen[NI], frame_seen[NI], last_ls[NI], last_fs[NI];
    int   hs_line[NI], hs_frame[NI], vs_frame[NI], von_frame[NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            cfg_t c;
            c = get_cfg(i);
            if (!agg_en) begin
                line_seen[i]  = 0;
                frame_seen[i] = 0;
            end else begin
                if (ls[i] === 1'b1) begin
                    if (line_seen[i] != 0) begin
                        check($sformatf("u%0d line period", i), cyc - last_ls[i], h_tot(c) * c.div);
                        check($sformatf("u%0d hsync cycles/line", i), hs_line[i], c.hs * c.div);
                    end
                    line_seen[i] = 1;
                    last_ls[i]   = cyc;
                    hs_line[i]   = 0;
                end
                if (fs[i] === 1'b1) begin
                    if (frame_seen[i] != 0) begin
                        check($sformatf("u%0d frame period", i), cyc - last_fs[i],
                              h_tot(c) * v_tot(c) * c.div);
                        check($sformatf("u%0d video cycles/frame", i), von_frame[i],
                              c.ha * c.va * c.div);
                        check($sformatf("u%0d vsync cycles/frame", i), vs_frame[i],
                              c.vs * h_tot(c) * c.div);
                        check($sformatf("u%0d hsync cycles/frame", i), hs_frame[i],
                              c.hs * v_tot(c) * c.div);
                    end
                    frame_seen[i] = 1;
                    last_fs[i]    = cyc;
                    von_frame[i]  = 0;
                    vs_frame[i]   = 0;
                    hs_frame[i]   = 0;
                end
                if (int'(hs[i]) == c.hpol) begin
                    hs_line[i]++;
                    hs_frame[i]++;
                end
                if (int'(vs[i]) == c.vpol) vs_frame[i]++;
                if (von[i] === 1'b1)       von_frame[i]++;
            end
        end
    end

    initial begin
        int k;
        bit found;

        // Reset held for 5 CLK; idle values visible during reset.
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset p_tick",   32'(pt[0]),  32'd0);
        check("reset pixel_X",  pxa[0],      32'd0);
        check("reset pixel_Y",  pya[0],      32'd0);
        check("reset hsync",    32'(hs[0]),  32'd1);
        check("reset vsync",    32'(vs[0]),  32'd1);
        check("reset video_on", 32'(von[0]), 32'd1);
        check("reset hsync pos pol", 32'(hs[4]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First tick arrives CLK_DIV cycles after release with frame_start.
        k = 0;
        found = 0;
        while (k < 10 && !found) begin
            @(negedge clk);
            k++;
            if (pt[0] === 1'b1) found = 1;
        end
        check("first tick latency", k, 32'd2);
`ifndef VGA_TIMING_OUT_REG_EN
        check("first tick frame_start", 32'(fs[0]), 32'd1);
`endif

        // Long reset-free run for period and pulse-width statistics.
        @(posedge clk);
        #1 agg_en = 1'b1;
        repeat (4000) @(posedge clk);
        #1 agg_en = 1'b0;

        // Reset mid-frame while u1 sits inside its horizontal sync pulse.
        found = 0;
        for (int j = 0; j < 2000 && !found; j++) begin
            @(negedge clk);
            if (pxa[1] == 20 && pya[1] == 7) found = 1;
        end
        check("reach u1 (20,7)", 32'(found), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid-frame reset pixel_X", pxa[1], 32'd0);
        check("mid-frame reset pixel_Y", pya[1], 32'd0);
        check("mid-frame reset hsync",   32'(hs[1]), 32'd1);
        check("mid-frame reset vsync",   32'(vs[1]), 32'd1);

        // Random reset pulses of 1..3 CLK at random points.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(900, 20)) @(posedge clk);
            #1 rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1 rst = 1'b0;
        end

        // Second clean window after the random restarts.
        @(posedge clk);
        #1 agg_en = 1'b1;
        repeat (2500) @(posedge clk);
        #1 agg_en = 1'b0;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
